ray_stepper: RTL and testbench
==============================

Name: ray_stepper

Overview:
- Upstream sequencer for the 3-lane fixed-point vector adder (latency 2, packed 96-bit vectors).
- Marches a point along a ray: p0 = origin, p(k+1) = p(k) + dir, for num_steps steps.
- Drives the adder's operand and new_data inputs and consumes its result and valid.
- Streams each new point downstream with valid/ready backpressure, so it sits directly in front of the adder in the raytracing pipeline.

Parameters:
CNT_W, 16, width of the step counter and of num_steps.
TIMEOUT, 15, cycles spent in WAIT without add_valid before the run is aborted (must be >= 3).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  run request, sampled only in IDLE
origin  in  96  start point; lane i = bits [32*i+:32], signed Q16.16, lane 0 = x
dir  in  96  step vector, same packing
num_steps  in  CNT_W  number of points to emit
busy  out  1  high from the cycle after an accepted start until DONE/abort completes
done  out  1  one-cycle pulse at end of run (normal, zero-length or abort)
error  out  1  sticky timeout flag; cleared by the next accepted start
add_new_data  out  1  one-cycle issue strobe to adder
add_v1  out  96  adder operand 1 (current position)
add_v2  out  96  adder operand 2 (dir)
add_r  in  96  adder result
add_valid  in  1  adder output_valid
point  out  96  emitted point
point_valid  out  1  point available
point_ready  in  1  downstream accepts point

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; internal pos, step, cnt, timer = 0.
- All outputs are registered. add_v1/add_v2 are held stable from ISSUE until add_valid is sampled.
- IDLE:
  - start=1 and num_steps!=0: latch pos<=origin, step<=dir, cnt<=num_steps, error<=0, busy<=1, go to ISSUE.
  - start=1 and num_steps==0: error<=0, done pulses next cycle, stay IDLE, no issue, no point.
- start in any other state: ignored.
- ISSUE:
  - add_new_data=1 for exactly this one cycle; add_v1=pos, add_v2=step.
  - Clear timer, go to WAIT.
- WAIT:
  - timer increments each cycle.
  - add_valid=1: pos<=add_r, point<=add_r, point_valid<=1, go to EMIT.
  - timer reaches TIMEOUT with no add_valid: error<=1, done pulse, busy<=0, go to IDLE (abort, no point).
- add_valid outside WAIT: ignored, with no state change.
- EMIT:
  - point/point_valid held until point_ready=1 is sampled with point_valid=1.
  - On handshake: point_valid<=0 and cnt<=cnt-1.
  - If cnt was 1, go to DONE; else go to ISSUE.
- DONE: done=1 for one cycle, busy<=0, go to IDLE. A new start is accepted in the following cycle (in IDLE).
- Per-step timing with point_ready held 1: ISSUE(1) + WAIT(2) + EMIT(1) = 4 cycles per point.
- Arithmetic: none inside the block. Lane overflow wraps as defined by the adder and pos keeps the wrapped value.
- Counter: cnt never underflows; num_steps = 2^CNT_W-1 must run to completion.
- Reset mid-run: aborts immediately. No done pulse; outputs are 0 after reset.

Test Plan:
- Normal run: origin=(0x00010000,0x00020000,0x00030000), dir=(0x00008000,0,0xFFFF0000), num_steps=3, ready=1, real vector_add attached -> points (0x00018000,0x00020000,0x00020000), (0x00020000,0x00020000,0x00010000), (0x00028000,0x00020000,0x00000000). Points spaced 4 cycles apart; done one cycle after the third handshake; error=0.
- Backpressure: same run, point_ready low for 5 cycles at each point -> point held stable, no extra add_new_data, cnt unchanged; same 3 values; each step lengthens by 5 cycles.
- Zero steps: num_steps=0, start -> done pulse, busy stays 0, no add_new_data, no point_valid.
- Timeout: adder model never asserts add_valid, TIMEOUT=15 -> after 15 WAIT cycles error=1, done pulse, busy=0, no point. Next start with num_steps=1 clears error and completes normally.
- Wrap and ignore: origin x=0x7FFF0000, dir x=0x00010000, num_steps=1 -> point x=0x80000000. start pulsed while busy and a spurious add_valid in EMIT are both ignored (exactly one point emitted).
- Reset mid-run: assert rst during WAIT of step 2 of a 5-step run -> all outputs 0 immediately, no done pulse. A fresh start afterwards emits from the new origin.

Source files
------------

// File: rtl/ray_stepper.sv
// Ray marcher: walks p(k+1) = p(k) + dir through an external 2-cycle vector
// adder and streams each point downstream with valid/ready backpressure.
module ray_stepper #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [95:0]      origin,
  input  logic [95:0]      dir,
  input  logic [CNT_W-1:0] num_steps,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             add_new_data,
  output logic [95:0]      add_v1,
  output logic [95:0]      add_v2,
  input  logic [95:0]      add_r,
  input  logic             add_valid,
  output logic [95:0]      point,
  output logic             point_valid,
  input  logic             point_ready
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [95:0]      pos, pos_d;
  logic [95:0]      step, step_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [TW-1:0]    timer, timer_d;
  logic             busy_d, done_d, error_d, add_new_data_d, point_valid_d;
  logic [95:0]      add_v1_d, add_v2_d, point_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pos          <= '0;
      step         <= '0;
      cnt          <= '0;
      timer        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      add_new_data <= 1'b0;
      add_v1       <= '0;
      add_v2       <= '0;
      point        <= '0;
      point_valid  <= 1'b0;
    end else begin
      state        <= state_d;
      pos          <= pos_d;
      step         <= step_d;
      cnt          <= cnt_d;
      timer        <= timer_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      add_new_data <= add_new_data_d;
      add_v1       <= add_v1_d;
      add_v2       <= add_v2_d;
      point        <= point_d;
      point_valid  <= point_valid_d;
    end
  end

  // Outputs are registered, so the issue strobe and operands are loaded on
  // the transition into ISSUE rather than while sitting in it.
  always_comb begin
    state_d        = state;
    pos_d          = pos;
    step_d         = step;
    cnt_d          = cnt;
    timer_d        = timer;
    busy_d         = busy;
    done_d         = 1'b0;
    error_d        = error;
    add_new_data_d = 1'b0;
    add_v1_d       = add_v1;
    add_v2_d       = add_v2;
    point_d        = point;
    point_valid_d  = point_valid;

    case (state)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (num_steps != '0) begin
            pos_d          = origin;
            step_d         = dir;
            cnt_d          = num_steps;
            busy_d         = 1'b1;
            add_new_data_d = 1'b1;
            add_v1_d       = origin;
            add_v2_d       = dir;
            state_d        = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (add_valid) begin
          pos_d         = add_r;
          point_d       = add_r;
          point_valid_d = 1'b1;
          state_d       = S_EMIT;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_EMIT: begin
        if (point_ready) begin
          point_valid_d = 1'b0;
          cnt_d         = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            add_new_data_d = 1'b1;
            add_v1_d       = pos;
            add_v2_d       = step;
            state_d        = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ray_stepper.sv
// Bench for ray_stepper with a behavioural 2-cycle vector adder attached.
module tb_ray_stepper;
  logic        clk = 1'b0;
  logic        rst, start, add_valid, point_ready;
  logic [95:0] origin, dir, add_r, add_v1, add_v2, point;
  logic [15:0] num_steps;
  logic        busy, done, error, add_new_data, point_valid;

  int cmp = 0;
  int err = 0;
  int cyc = 0;

  ray_stepper #(.CNT_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .origin(origin), .dir(dir),
    .num_steps(num_steps), .busy(busy), .done(done), .error(error),
    .add_new_data(add_new_data), .add_v1(add_v1), .add_v2(add_v2),
    .add_r(add_r), .add_valid(add_valid), .point(point),
    .point_valid(point_valid), .point_ready(point_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] vadd(input logic [95:0] a, input logic [95:0] b);
    logic [95:0] r;
    for (int i = 0; i < 3; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    return r;
  endfunction

  // adder model: operands taken on new_data, result valid two cycles later
  logic        adder_on = 1'b1, spur = 1'b0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [95:0] s1_r = '0, s2_r = '0, junk = '0;
  always @(posedge clk) begin
    s1_v <= add_new_data && adder_on;
    s1_r <= vadd(add_v1, add_v2);
    s2_v <= s1_v;
    s2_r <= s1_r;
  end
  assign add_valid = s2_v | spur;
  assign add_r     = spur ? junk : s2_r;

  int          n_issue, n_done, n_pv, n_busy, last_done_cyc;
  logic [95:0] pts[$];
  int          hs[$];
  always @(negedge clk) begin
    #1;
    if (add_new_data) n_issue++;
    if (done) begin n_done++; last_done_cyc = cyc; end
    if (point_valid) n_pv++;
    if (busy) n_busy++;
    if (point_valid && point_ready) begin pts.push_back(point); hs.push_back(cyc); end
  end

  task automatic clear_mon();
    n_issue = 0; n_done = 0; n_pv = 0; n_busy = 0; last_done_cyc = -1;
    pts.delete(); hs.delete();
  endtask

  task automatic start_run(input logic [95:0] o, input logic [95:0] d,
                           input logic [15:0] n, output int sc);
    @(negedge clk);
    origin = o; dir = d; num_steps = n; start = 1'b1; sc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string nm);
    int k = 0;
    while (done !== 1'b1 && k < lim) begin @(negedge clk); k++; end
    cmp++;
    if (done !== 1'b1) begin
      err++;
      $display("FAIL %s: done not seen within %0d cycles (got 0, need 1)", nm, lim);
    end
  endtask

  localparam logic [95:0] O3 = {32'h00030000, 32'h00020000, 32'h00010000};
  localparam logic [95:0] D3 = {32'hFFFF0000, 32'h00000000, 32'h00008000};
  logic [95:0] exp3[3];

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; origin = '0; dir = '0; num_steps = '0; point_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmp++;
    if ({busy, done, error, add_new_data, point_valid} !== 5'b0 ||
        add_v1 !== '0 || add_v2 !== '0 || point !== '0) begin
      err++;
      $display("FAIL reset_outputs: busy/done/error/new/pv=%b%b%b%b%b v1=%h v2=%h pt=%h need all 0",
               busy, done, error, add_new_data, point_valid, add_v1, add_v2, point);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cmp++;
    if ({busy, done, add_new_data, point_valid} !== 4'b0) begin
      err++;
      $display("FAIL idle_after_reset: busy/done/new/pv=%b%b%b%b need 0000",
               busy, done, add_new_data, point_valid);
    end
  endtask

  task automatic test_normal();
    int sc;
    clear_mon(); point_ready = 1'b1;
    start_run(O3, D3, 16'd3, sc);
    wait_done(100, "normal_done");
    repeat (2) @(negedge clk);
    cmp++;
    if (pts.size() != 3) begin err++; $display("FAIL normal_count: got %0d points need 3", pts.size()); end
    for (int i = 0; i < 3 && i < pts.size(); i++) begin
      cmp++;
      if (pts[i] !== exp3[i]) begin err++; $display("FAIL normal_point%0d: got %h need %h", i, pts[i], exp3[i]); end
    end
    if (hs.size() == 3) begin
      cmp++;
      if (hs[0] != sc + 4 || hs[1] - hs[0] != 4 || hs[2] - hs[1] != 4) begin
        err++;
        $display("FAIL normal_spacing: handshakes at +%0d,+%0d,+%0d need +4,+8,+12",
                 hs[0] - sc, hs[1] - sc, hs[2] - sc);
      end
      cmp++;
      if (last_done_cyc != hs[2] + 1) begin
        err++;
        $display("FAIL normal_done_time: done at %0d need %0d", last_done_cyc, hs[2] + 1);
      end
    end
    cmp++;
    if (n_issue != 3 || n_done != 1 || error !== 1'b0) begin
      err++;
      $display("FAIL normal_counts: issues=%0d dones=%0d error=%b need 3 1 0", n_issue, n_done, error);
    end
  endtask

  task automatic test_backpressure();
    int sc, k;
    logic [95:0] held;
    clear_mon(); point_ready = 1'b0;
    start_run(O3, D3, 16'd3, sc);
    for (int p = 0; p < 3; p++) begin
      k = 0;
      while (point_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      cmp++;
      if (point_valid !== 1'b1) begin err++; $display("FAIL bp_valid%0d: point_valid 0 after 50 cycles need 1", p); break; end
      held = point;
      for (int j = 0; j < 5; j++) begin
        cmp++;
        if (point !== held || point_valid !== 1'b1 || add_new_data !== 1'b0) begin
          err++;
          $display("FAIL bp_hold%0d_%0d: pt=%h pv=%b new=%b need %h 1 0", p, j, point, point_valid, add_new_data, held);
        end
        @(negedge clk);
      end
      point_ready = 1'b1;
      @(negedge clk);
      point_ready = 1'b0;
    end
    point_ready = 1'b1;
    wait_done(60, "bp_done");
    repeat (2) @(negedge clk);
    cmp++;
    if (pts.size() != 3 || n_issue != 3 || n_pv != 18) begin
      err++;
      $display("FAIL bp_counts: points=%0d issues=%0d pv_cycles=%0d need 3 3 18", pts.size(), n_issue, n_pv);
    end
    for (int i = 0; i < 3 && i < pts.size(); i++) begin
      cmp++;
      if (pts[i] !== exp3[i]) begin err++; $display("FAIL bp_point%0d: got %h need %h", i, pts[i], exp3[i]); end
    end
    if (hs.size() == 3) begin
      cmp++;
      if (hs[1] - hs[0] != 9 || hs[2] - hs[1] != 9) begin
        err++;
        $display("FAIL bp_spacing: gaps %0d,%0d need 9,9", hs[1] - hs[0], hs[2] - hs[1]);
      end
    end
  endtask

  task automatic test_random();
    int sc, k, n;
    logic [95:0] o, d, p;
    logic [95:0] model[$];
    for (int r = 0; r < 4; r++) begin
      o = {$urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom};
      n = $urandom_range(1, 6);
      model.delete();
      p = o;
      for (int i = 0; i < n; i++) begin p = vadd(p, d); model.push_back(p); end
      clear_mon();
      start_run(o, d, 16'(n), sc);
      k = 0;
      while (done !== 1'b1 && k < 400) begin
        @(negedge clk);
        point_ready = 1'($urandom_range(0, 1));
        k++;
      end
      point_ready = 1'b1;
      cmp++;
      if (done !== 1'b1) begin err++; $display("FAIL rand%0d_done: done not seen (got 0 need 1)", r); end
      repeat (2) @(negedge clk);
      cmp++;
      if (pts.size() != n || n_issue != n || n_done != 1 || error !== 1'b0) begin
        err++;
        $display("FAIL rand%0d_counts: points=%0d issues=%0d dones=%0d err=%b need %0d %0d 1 0",
                 r, pts.size(), n_issue, n_done, error, n, n);
      end
      for (int i = 0; i < n && i < pts.size(); i++) begin
        cmp++;
        if (pts[i] !== model[i]) begin err++; $display("FAIL rand%0d_point%0d: got %h need %h", r, i, pts[i], model[i]); end
      end
    end
  endtask

  task automatic test_zero();
    int sc;
    clear_mon();
    start_run(O3, D3, 16'd0, sc);
    wait_done(5, "zero_done");
    repeat (3) @(negedge clk);
    cmp++;
    if (last_done_cyc != sc + 1 || n_done != 1 || n_busy != 0 || n_issue != 0 || n_pv != 0) begin
      err++;
      $display("FAIL zero_steps: done_at=+%0d dones=%0d busy=%0d issues=%0d pv=%0d need +1 1 0 0 0",
               last_done_cyc - sc, n_done, n_busy, n_issue, n_pv);
    end
  endtask

  task automatic test_timeout();
    int sc;
    adder_on = 1'b0;
    clear_mon();
    start_run(O3, D3, 16'd2, sc);
    wait_done(40, "timeout_done");
    cmp++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      err++;
      $display("FAIL timeout_flags: error=%b busy=%b need 1 0", error, busy);
    end
    repeat (3) @(negedge clk);
    cmp++;
    if (last_done_cyc != sc + 17 || n_pv != 0 || n_issue != 1 || error !== 1'b1) begin
      err++;
      $display("FAIL timeout_abort: done_at=+%0d pv=%0d issues=%0d error=%b need +17 0 1 1",
               last_done_cyc - sc, n_pv, n_issue, error);
    end
    adder_on = 1'b1;
    clear_mon();
    start_run(O3, D3, 16'd1, sc);
    cmp++;
    if (error !== 1'b0) begin err++; $display("FAIL timeout_clear: error=%b need 0", error); end
    wait_done(30, "timeout_recover_done");
    repeat (2) @(negedge clk);
    cmp++;
    if (pts.size() != 1 || error !== 1'b0) begin
      err++;
      $display("FAIL timeout_recover: points=%0d error=%b need 1 0", pts.size(), error);
    end else if (pts[0] !== exp3[0]) begin
      err++;
      $display("FAIL timeout_recover_point: got %h need %h", pts[0], exp3[0]);
    end
  endtask

  task automatic test_wrap_ignore();
    int sc;
    logic [95:0] o, d, e;
    o = {$urandom, $urandom, 32'h7FFF0000};
    d = {$urandom, $urandom, 32'h00010000};
    e = vadd(o, d);
    clear_mon(); point_ready = 1'b0;
    start_run(o, d, 16'd1, sc);
    @(negedge clk);
    start = 1'b1; num_steps = 16'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    spur = 1'b1; junk = {$urandom, $urandom, $urandom};
    @(negedge clk);
    spur = 1'b0;
    cmp++;
    if (point_valid !== 1'b1 || point !== e) begin
      err++;
      $display("FAIL wrap_held: pv=%b pt=%h need 1 %h", point_valid, point, e);
    end
    point_ready = 1'b1;
    wait_done(30, "wrap_done");
    repeat (4) @(negedge clk);
    cmp++;
    if (pts.size() != 1 || n_issue != 1 || n_done != 1) begin
      err++;
      $display("FAIL wrap_counts: points=%0d issues=%0d dones=%0d need 1 1 1", pts.size(), n_issue, n_done);
    end else begin
      cmp++;
      if (pts[0][31:0] !== 32'h80000000 || pts[0] !== e) begin
        err++;
        $display("FAIL wrap_point: got %h need %h", pts[0], e);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int sc;
    logic [95:0] o2, d2;
    clear_mon(); point_ready = 1'b1;
    start_run(O3, D3, 16'd5, sc);
    repeat (5) @(negedge clk);
    cmp++;
    if (n_issue != 2 || busy !== 1'b1 || point_valid !== 1'b0) begin
      err++;
      $display("FAIL midrun_setup: issues=%0d busy=%b pv=%b need 2 1 0", n_issue, busy, point_valid);
    end
    rst = 1'b1;
    #1;
    cmp++;
    if ({busy, done, error, add_new_data, point_valid} !== 5'b0 ||
        add_v1 !== '0 || add_v2 !== '0 || point !== '0) begin
      err++;
      $display("FAIL midrun_reset: busy/done/error/new/pv=%b%b%b%b%b v1=%h v2=%h pt=%h need all 0",
               busy, done, error, add_new_data, point_valid, add_v1, add_v2, point);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cmp++;
    if (n_done != 0 || busy !== 1'b0) begin
      err++;
      $display("FAIL midrun_no_done: dones=%0d busy=%b need 0 0", n_done, busy);
    end
    o2 = {$urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom};
    clear_mon();
    start_run(o2, d2, 16'd2, sc);
    wait_done(30, "midrun_fresh_done");
    repeat (2) @(negedge clk);
    cmp++;
    if (pts.size() != 2) begin
      err++;
      $display("FAIL midrun_fresh_count: got %0d points need 2", pts.size());
    end else begin
      cmp++;
      if (pts[0] !== vadd(o2, d2) || pts[1] !== vadd(vadd(o2, d2), d2)) begin
        err++;
        $display("FAIL midrun_fresh_points: got %h %h need %h %h",
                 pts[0], pts[1], vadd(o2, d2), vadd(vadd(o2, d2), d2));
      end
    end
  endtask

  initial begin
    exp3[0] = {32'h00020000, 32'h00020000, 32'h00018000};
    exp3[1] = {32'h00010000, 32'h00020000, 32'h00020000};
    exp3[2] = {32'h00000000, 32'h00020000, 32'h00028000};
    test_reset();
    test_normal();
    test_backpressure();
    test_random();
    test_zero();
    test_timeout();
    test_wrap_ignore();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
